// File: rtl/mips_run_monitor_if.sv
// rtl/mips_run_monitor_if.sv - register-file read port and dump stream between the run monitor and its consumer
interface mips_run_monitor_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic              dump_valid;
    logic              dump_ready;
    logic              dump_is_pc;
    logic [ADDR_W-1:0] dump_index;
    logic [DATA_W-1:0] dump_data;

    modport master (
        output rf_rd_addr,
        input  rf_rd_data,
        output dump_valid,
        input  dump_ready,
        output dump_is_pc,
        output dump_index,
        output dump_data
    );

    modport slave (
        input  rf_rd_addr,
        output rf_rd_data,
        input  dump_valid,
        output dump_ready,
        input  dump_is_pc,
        input  dump_index,
        input  dump_data
    );
endinterface

// File: rtl/mips_run_monitor.sv
// rtl/mips_run_monitor.sv - runs the CPU until timeout or PC stall, then streams the PC and register file
module mips_run_monitor #(
    parameter int DATA_W        = 32,
    parameter int NUM_REGS      = 32,
    parameter int ADDR_W        = 5,
    parameter int MAX_CYCLES    = 820,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   pc_in,
    output logic                run_en,
    mips_run_monitor_if.master  dump_bus,
    output logic [1:0]          halt_cause,
    output logic [CNT_W-1:0]    cycle_count,
    output logic                busy,
    output logic                done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DUMP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0]  LAST_CYCLE  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LAST_STABLE = CNT_W'((STABLE_CYCLES > 0) ? STABLE_CYCLES - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_REG    = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  stable_cnt;
    logic [DATA_W-1:0] pc_prev;
    logic [ADDR_W-1:0] idx;
    logic              pc_same;
    logic              timeout_hit;
    logic              stall_hit;
    logic              beat_xfer;

    assign pc_same     = (pc_in == pc_prev);
    assign timeout_hit = (cycle_count == LAST_CYCLE);
    assign stall_hit   = (STABLE_CYCLES > 0) && pc_same && (stable_cnt == LAST_STABLE);
    assign beat_xfer   = dump_bus.dump_valid && dump_bus.dump_ready;

    assign run_en              = (state == S_RUN);
    assign busy                = (state == S_RUN) || (state == S_DUMP);
    assign done                = (state == S_DONE);
    assign dump_bus.rf_rd_addr = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= S_IDLE;
            stable_cnt          <= '0;
            pc_prev             <= '0;
            idx                 <= '0;
            cycle_count         <= '0;
            halt_cause          <= 2'b00;
            dump_bus.dump_valid <= 1'b0;
            dump_bus.dump_is_pc <= 1'b0;
            dump_bus.dump_index <= '0;
            dump_bus.dump_data  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RUN;
                        cycle_count <= '0;
                        stable_cnt  <= '0;
                        halt_cause  <= 2'b00;
                        pc_prev     <= pc_in;
                    end
                end
                S_RUN: begin
                    pc_prev    <= pc_in;
                    stable_cnt <= pc_same ? stable_cnt + 1'b1 : '0;
                    // cycle_count freezes on the halting cycle so it reports the last RUN cycle
                    if (timeout_hit || stall_hit) begin
                        state               <= S_DUMP;
                        halt_cause          <= {stall_hit, timeout_hit};
                        dump_bus.dump_valid <= 1'b1;
                        dump_bus.dump_is_pc <= 1'b1;
                        dump_bus.dump_data  <= pc_in;
                        dump_bus.dump_index <= '0;
                        idx                 <= '0;
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                S_DUMP: begin
                    if (beat_xfer) begin
                        if (dump_bus.dump_is_pc) begin
                            dump_bus.dump_is_pc <= 1'b0;
                            dump_bus.dump_data  <= dump_bus.rf_rd_data;
                            dump_bus.dump_index <= '0;
                            idx                 <= ADDR_W'(1);
                        end else if (dump_bus.dump_index != LAST_REG) begin
                            dump_bus.dump_data  <= dump_bus.rf_rd_data;
                            dump_bus.dump_index <= idx;
                            idx                 <= idx + 1'b1;
                        end else begin
                            dump_bus.dump_valid <= 1'b0;
                            state               <= S_DONE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/mips_run_monitor.md
Name: mips_run_monitor

Overview:
Synthesizable run-control and state-dump block for the MIPS core. It runs the CPU for a bounded cycle budget or until the PC stalls, then freezes the core and streams the final PC followed by every register-file entry over a valid/ready handshake. It is the parametrised, in-design successor to fixed-delay bench dumps: register count, widths, timeout and stall detection are configurable, and it supports back-pressure and restart. It sits beside the CPU and reads the register file through a dedicated asynchronous read port.

Parameters:
DATA_W, 32, register and PC data width
NUM_REGS, 32, register-file entries dumped (indices 0..NUM_REGS-1)
ADDR_W, 5, register index width; must satisfy 2**ADDR_W >= NUM_REGS
MAX_CYCLES, 820, RUN cycle budget before timeout (>=1)
STABLE_CYCLES, 4, consecutive unchanged-PC cycles that declare a halt; 0 disables stall detection
CNT_W, 16, cycle counter width; must hold MAX_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a run; honoured only in IDLE or DONE
pc_in  in  DATA_W  current CPU program counter
run_en  out  1  CPU advance enable; high only in RUN
rf_rd_addr  out  ADDR_W  register-file read address (combinational from the internal index)
rf_rd_data  in  DATA_W  asynchronous register-file read data for rf_rd_addr
dump_valid  out  1  dump beat valid
dump_ready  in  1  consumer accepts the beat
dump_is_pc  out  1  current beat carries the PC
dump_index  out  ADDR_W  register index of the current beat (0 on the PC beat)
dump_data  out  DATA_W  beat payload
halt_cause  out  2  01 timeout, 10 PC stall, 11 both in the same cycle, 00 none
cycle_count  out  CNT_W  RUN cycles elapsed in the last or current run
busy  out  1  high in RUN or DUMP
done  out  1  high in DONE

Behaviour:
- Reset: all outputs are 0, state is IDLE, and internal counters and pc_prev are cleared. Reset takes effect immediately in any state, including mid-RUN or mid-DUMP; any beat in flight is discarded.
- States: IDLE, RUN, DUMP, DONE.
- IDLE/DONE + start=1: at the next edge, go to RUN. Clear cycle_count, stable counter and halt_cause, and load pc_prev<=pc_in. start in RUN/DUMP is ignored.
- RUN: run_en=1. cycle_count increments each cycle; the first RUN cycle shows 0.
  - Stall tracking: stable counter increments when pc_in==pc_prev and resets to 0 otherwise. pc_prev<=pc_in every cycle.
  - Timeout condition: cycle_count==MAX_CYCLES-1, so RUN lasts exactly MAX_CYCLES cycles.
  - Stall condition (STABLE_CYCLES>0): pc_in==pc_prev while the stable counter == STABLE_CYCLES-1.
  - When either condition holds, at the next edge: go to DUMP, latch halt_cause, freeze cycle_count, run_en<=0, dump_valid<=1, dump_is_pc<=1, dump_data<=pc_in, dump_index<=0, internal index<=0.
- DUMP:
  - rf_rd_addr = internal index.
  - Payload and flags are stable while dump_valid && !dump_ready.
  - On the PC-beat handshake: dump_is_pc<=0, dump_data<=rf_rd_data (entry 0), dump_index<=0, index<=1.
  - On a register-beat handshake with dump_index<NUM_REGS-1: load entry index, dump_index<=index, index<=index+1.
  - On the handshake with dump_index==NUM_REGS-1: dump_valid<=0, go to DONE.
  - Total beats = NUM_REGS+1. With dump_ready held high, one beat transfers per cycle and the last accept occurs NUM_REGS+1 cycles after entering DUMP.
- DONE: done=1. halt_cause and cycle_count are held until the next start.
- run_en is 0 outside RUN, so the register file is static during DUMP.
- Counters never wrap: a run always ends at MAX_CYCLES.

Test Plan:
1. Timeout: MAX_CYCLES=10, pc_in +4 per cycle from 0, dump_ready=1 → run_en high exactly 10 cycles; halt_cause=01; cycle_count=9; first beat is_pc=1 with data=0x24; then 32 beats, index 0..31, matching preloaded RF.
2. Stall: STABLE_CYCLES=4, pc_in=0,4,8 then held at 0x0C → DUMP is entered 4 cycles after 0x0C first repeats; halt_cause=10; PC beat data=0x0C.
3. Simultaneous: stall condition and timeout on the same cycle → halt_cause=11; DUMP proceeds normally.
4. Back-pressure: dump_ready toggles 1,0,0,1… → no beat lost or duplicated; data, index and is_pc are stable while stalled; 33 beats total; done rises one cycle after the last accept.
5. Reset mid-dump: assert rst after beat 5 → all outputs read 0 immediately. Then start → a fresh run with cycle_count restarting from 0.
6. Restart: start in DONE → RUN entered, halt_cause cleared to 00; start pulsed during RUN or DUMP has no effect.
